// File: rtl/rv_regfile_sb.sv
// rv_regfile_sb: integer register file with a pending-write scoreboard and a sequential clear engine.
// Optional same-cycle writeback-to-read bypass is enabled by defining RV_REGFILE_BYPASS_EN.
module rv_regfile_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 16,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear_req,
    output logic            ready,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_addr,
    input  logic            rd_we,
    input  logic [AW-1:0]   rd_addr,
    input  logic [XLEN-1:0] rd_data
);

    typedef enum logic [0:0] {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

    localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] PTR_FIRST = AW'(1);
    localparam logic [AW-1:0] PTR_LAST  = AW'(NREGS - 1);

    if ((NREGS != 16) && (NREGS != 32)) begin : g_bad_nregs
        $error("rv_regfile_sb: NREGS must be 16 or 32");
    end

    state_t            state_r;
    logic [AW-1:0]     ptr_r;
    logic              ready_r;
    logic [NREGS-1:0]  busy_r;
    logic [XLEN-1:0]   regs_r [NREGS];

    logic              accept_s;
    logic              wr_fire_s;
    logic              iss_fire_s;
    logic [1:0][AW-1:0]   port_addr_s;
    logic [1:0][XLEN-1:0] port_data_s;
    logic [1:0]           port_busy_s;

    // Qualify writeback and issue: only in RUN, and dropped when a clear is being requested.
    always_comb begin
        accept_s   = (state_r == ST_RUN) && !clear_req;
        wr_fire_s  = accept_s && rd_we && (rd_addr != ADDR_ZERO);
        iss_fire_s = accept_s && iss_valid && (iss_addr != ADDR_ZERO);
    end

    // Control FSM and scoreboard; the issue update comes last so set beats clear on the same address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_CLEAR;
            ptr_r   <= PTR_FIRST;
            ready_r <= 1'b0;
            busy_r  <= {NREGS{1'b0}};
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    busy_r <= {NREGS{1'b0}};
                    if (ptr_r == PTR_LAST) begin
                        state_r <= ST_RUN;
                        ready_r <= 1'b1;
                        ptr_r   <= PTR_FIRST;
                    end else begin
                        ptr_r <= ptr_r + PTR_FIRST;
                    end
                end
                ST_RUN: begin
                    if (clear_req) begin
                        state_r <= ST_CLEAR;
                        ready_r <= 1'b0;
                        ptr_r   <= PTR_FIRST;
                        busy_r  <= {NREGS{1'b0}};
                    end else begin
                        if (wr_fire_s) begin
                            busy_r[rd_addr] <= 1'b0;
                        end
                        if (iss_fire_s) begin
                            busy_r[iss_addr] <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= ST_CLEAR;
                    ready_r <= 1'b0;
                    ptr_r   <= PTR_FIRST;
                    busy_r  <= {NREGS{1'b0}};
                end
            endcase
        end
    end

    // Storage array without reset so it maps onto distributed RAM; entry 0 is never written.
    always_ff @(posedge clk) begin
        if (state_r == ST_CLEAR) begin
            regs_r[ptr_r] <= {XLEN{1'b0}};
        end else if (wr_fire_s) begin
            regs_r[rd_addr] <= rd_data;
        end
    end

    assign port_addr_s = {rs2_addr, rs1_addr};

    // Combinational read ports; x0 and the whole file read as zero/not-busy while clearing.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            port_data_s[p] = {XLEN{1'b0}};
            port_busy_s[p] = 1'b0;
            if (ready_r && (port_addr_s[p] != ADDR_ZERO)) begin
`ifdef RV_REGFILE_BYPASS_EN
                if (wr_fire_s && (rd_addr == port_addr_s[p])) begin
                    port_data_s[p] = rd_data;
                    port_busy_s[p] = iss_fire_s && (iss_addr == port_addr_s[p]);
                end else begin
                    port_data_s[p] = regs_r[port_addr_s[p]];
                    port_busy_s[p] = busy_r[port_addr_s[p]];
                end
`else
                port_data_s[p] = regs_r[port_addr_s[p]];
                port_busy_s[p] = busy_r[port_addr_s[p]];
`endif
            end else begin
                port_data_s[p] = {XLEN{1'b0}};
                port_busy_s[p] = 1'b0;
            end
        end
    end

    assign ready    = ready_r;
    assign rs1_data = port_data_s[0];
    assign rs2_data = port_data_s[1];
    assign rs1_busy = port_busy_s[0];
    assign rs2_busy = port_busy_s[1];

endmodule

// File: tb/tb_rv_regfile_sb.sv
// Directed self-checking bench for rv_regfile_sb (16-entry main instance, 32-entry clear-length instance).
// Expectations for the same-cycle write/read case follow RV_REGFILE_BYPASS_EN.
module tb_rv_regfile_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        clear_req;
    logic        ready;
    logic [3:0]  rs1_addr, rs2_addr, iss_addr, rd_addr;
    logic [31:0] rs1_data, rs2_data, rd_data;
    logic        rs1_busy, rs2_busy, iss_valid, rd_we;

    logic        rst32_n;
    logic        ready32;
    logic [4:0]  rs1_addr32, rs2_addr32;
    logic [31:0] rs1_data32, rs2_data32;
    logic        rs1_busy32, rs2_busy32;
    logic        idle_b = 1'b0;
    logic [4:0]  idle_a = 5'd0;
    logic [31:0] idle_d = 32'd0;

    int checks = 0;
    int errors = 0;
    int n;

    rv_regfile_sb #(.XLEN(32), .NREGS(16)) dut (
        .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .ready(ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .iss_valid(iss_valid), .iss_addr(iss_addr),
        .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    rv_regfile_sb #(.XLEN(32), .NREGS(32)) dut32 (
        .clk(clk), .rst_n(rst32_n), .clear_req(idle_b), .ready(ready32),
        .rs1_addr(rs1_addr32), .rs2_addr(rs2_addr32), .rs1_data(rs1_data32), .rs2_data(rs2_data32),
        .rs1_busy(rs1_busy32), .rs2_busy(rs2_busy32), .iss_valid(idle_b), .iss_addr(idle_a),
        .rd_we(idle_b), .rd_addr(idle_a), .rd_data(idle_d)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (!ready && cnt < 200) begin
            tick();
            cnt++;
        end
    endtask

    initial begin
        rst_n = 1'b0; rst32_n = 1'b0; clear_req = 1'b0;
        rs1_addr = 4'd0; rs2_addr = 4'd0; iss_valid = 1'b0; iss_addr = 4'd0;
        rd_we = 1'b0; rd_addr = 4'd0; rd_data = 32'd0;
        rs1_addr32 = 5'd0; rs2_addr32 = 5'd0;
        #1;
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_rs1_data", rs1_data, 32'd0);
        chk("rst_rs2_data", rs2_data, 32'd0);
        chk("rst_busy", {30'd0, rs1_busy, rs2_busy}, 32'd0);
        tick(); tick();

        // Reset release: 15 clear cycles, then everything reads zero / idle.
        rst_n = 1'b1;
        wait_ready(n);
        chk("reset_clear_len", n, 32'd15);
        for (int a = 0; a < 16; a++) begin
            rs1_addr = 4'(a); rs2_addr = 4'(15 - a);
            #1;
            chk("init_rs1_data", rs1_data, 32'd0);
            chk("init_rs2_data", rs2_data, 32'd0);
            chk("init_busy", {30'd0, rs1_busy, rs2_busy}, 32'd0);
        end

        // Basic write, then x0 write is dropped.
        rd_we = 1'b1; rd_addr = 4'd5; rd_data = 32'hDEADBEEF;
        tick();
        rd_addr = 4'd0; rd_data = 32'h00001234;
        rs1_addr = 4'd5; rs2_addr = 4'd0;
        #1;
        chk("wr_x5", rs1_data, 32'hDEADBEEF);
        chk("rd_x0", rs2_data, 32'd0);
        tick();
        rd_we = 1'b0;
        #1;
        chk("x0_after_wr", rs2_data, 32'd0);
        chk("x0_busy", {31'd0, rs2_busy}, 32'd0);

        // Scoreboard: issue sets, writeback clears, simultaneous set wins.
        iss_valid = 1'b1; iss_addr = 4'd7;
        tick();
        iss_valid = 1'b0; rs1_addr = 4'd7;
        #1;
        chk("iss_x7_busy", {31'd0, rs1_busy}, 32'd1);
        rd_we = 1'b1; rd_addr = 4'd7; rd_data = 32'h00000055;
        tick();
        rd_we = 1'b0;
        #1;
        chk("wb_x7_busy", {31'd0, rs1_busy}, 32'd0);
        chk("wb_x7_data", rs1_data, 32'h00000055);
        rd_we = 1'b1; rd_data = 32'h00000066; iss_valid = 1'b1; iss_addr = 4'd7;
        tick();
        rd_we = 1'b0; iss_valid = 1'b0;
        #1;
        chk("setclr_x7_busy", {31'd0, rs1_busy}, 32'd1);
        chk("setclr_x7_data", rs1_data, 32'h00000066);

        // Same-cycle write/read of x3, which holds 0x11 and is busy beforehand.
        rd_we = 1'b1; rd_addr = 4'd3; rd_data = 32'h00000011;
        tick();
        rd_we = 1'b0; iss_valid = 1'b1; iss_addr = 4'd3;
        tick();
        iss_valid = 1'b0;
        rd_we = 1'b1; rd_addr = 4'd3; rd_data = 32'hA5A5A5A5; rs1_addr = 4'd3;
        #1;
`ifdef RV_REGFILE_BYPASS_EN
        chk("same_cyc_data", rs1_data, 32'hA5A5A5A5);
        chk("same_cyc_busy", {31'd0, rs1_busy}, 32'd0);
`else
        chk("same_cyc_data", rs1_data, 32'h00000011);
        chk("same_cyc_busy", {31'd0, rs1_busy}, 32'd1);
`endif
        tick();
        rd_we = 1'b0;
        #1;
        chk("next_cyc_data", rs1_data, 32'hA5A5A5A5);
        chk("next_cyc_busy", {31'd0, rs1_busy}, 32'd0);

        // Fill x1..x15, mark x2 busy, then clear with ignored traffic.
        for (int i = 1; i < 16; i++) begin
            rd_we = 1'b1; rd_addr = 4'(i); rd_data = 32'h100 + 32'(i);
            tick();
        end
        rd_we = 1'b0; iss_valid = 1'b1; iss_addr = 4'd2;
        tick();
        iss_valid = 1'b0; rs1_addr = 4'd15; rs2_addr = 4'd2;
        #1;
        chk("fill_x15", rs1_data, 32'h0000010F);
        chk("fill_x2_busy", {31'd0, rs2_busy}, 32'd1);
        clear_req = 1'b1; rd_we = 1'b1; rd_addr = 4'd4; rd_data = 32'h0BAD0BAD;
        iss_valid = 1'b1; iss_addr = 4'd9;
        tick();
        clear_req = 1'b0; iss_valid = 1'b0; rd_addr = 4'd6;
        #1;
        chk("clr_ready", {31'd0, ready}, 32'd0);
        chk("clr_rs1_data", rs1_data, 32'd0);
        wait_ready(n);
        chk("clear_req_len", n, 32'd15);
        rd_we = 1'b0;
        for (int a = 0; a < 16; a++) begin
            rs1_addr = 4'(a); rs2_addr = 4'(a);
            #1;
            chk("post_clr_data", rs1_data, 32'd0);
            chk("post_clr_data2", rs2_data, 32'd0);
            chk("post_clr_busy", {30'd0, rs1_busy, rs2_busy}, 32'd0);
        end

        // Reset mid-run: immediate effect.
        iss_valid = 1'b1; iss_addr = 4'd2;
        tick();
        iss_valid = 1'b0; rs1_addr = 4'd2;
        #1;
        chk("pre_rst_busy", {31'd0, rs1_busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_ready", {31'd0, ready}, 32'd0);
        chk("midrun_rst_busy", {31'd0, rs1_busy}, 32'd0);
        tick();
        rst_n = 1'b1;
        wait_ready(n);
        chk("midrun_rst_len", n, 32'd15);
        #1;
        chk("midrun_rst_x2_busy", {31'd0, rs1_busy}, 32'd0);

        // Reset mid-clear at ptr = 8: clear restarts from 1.
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (7) tick();
        rst_n = 1'b0;
        #1;
        chk("midclr_rst_ready", {31'd0, ready}, 32'd0);
        tick();
        rst_n = 1'b1;
        wait_ready(n);
        chk("midclr_rst_len", n, 32'd15);

        // 32-entry file takes 31 clear cycles.
        rst32_n = 1'b1;
        n = 0;
        while (!ready32 && n < 200) begin
            tick();
            n++;
        end
        chk("nregs32_clear_len", n, 32'd31);
        rs1_addr32 = 5'd31; rs2_addr32 = 5'd0;
        #1;
        chk("nregs32_x31", rs1_data32, 32'd0);
        chk("nregs32_x0", rs2_data32, 32'd0);
        chk("nregs32_busy", {30'd0, rs1_busy32, rs2_busy32}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
